rot_shift_unit: RTL and testbench
=================================

ROT_SHIFT_UNIT -- requirements
Module: rot_shift_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits; legal values are powers of two, 2 or more.
REQ-002 The block SHALL have parameter STEP, default 1, meaning the maximum bit positions shifted per BUSY cycle; legal range is 1..WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operation request is present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a request.
REQ-007 The block SHALL have port num, input, WIDTH bits: the operand.
REQ-008 The block SHALL have port amt, input, clog2(WIDTH) bits: the shift amount.
REQ-009 The block SHALL have port mode, input, 2 bits: 00 ROR, 01 ROL, 10 SRL, 11 SRA.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 The block SHALL have port result, output, WIDTH bits: the shifted or rotated value.
REQ-013 Under ROT_SHIFT_FLAGS_EN only, the block SHALL have ports flag_c and flag_z, outputs, 1 bit each: carry and zero.

Function
REQ-014 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-015 in_ready SHALL equal (state==IDLE) and not rst.
REQ-016 A request SHALL be accepted on any edge where in_valid and in_ready are both high; this edge latches num, mode and amt.
REQ-017 On acceptance, the next state SHALL be BUSY if amt is not 0, and DONE if amt is 0 (result = num).
REQ-018 Each BUSY edge SHALL apply a shift of s = min(STEP, remaining) in the latched mode and decrement remaining by s; when remaining reaches 0, the next state SHALL be DONE.
REQ-019 If acceptance occurs in cycle N, out_valid SHALL first be high in cycle N+1+ceil(amt/STEP).
REQ-020 The mode results SHALL be: ROR = bit i takes bit (i+amt) mod WIDTH; ROL = bit i takes bit (i-amt) mod WIDTH; SRL fills zeros at the MSB; SRA fills copies of the original num MSB.
REQ-021 out_valid SHALL equal (state==DONE); result and flags SHALL stay stable while out_valid is high.
REQ-022 In DONE, an edge with out_ready high SHALL move the state to IDLE; with out_ready low the block SHALL hold DONE indefinitely.
REQ-023 There SHALL be no back-to-back acceptance: in_ready is low during BUSY and DONE, and in_valid is ignored then.
REQ-024 The maximum amount, WIDTH-1, SHALL complete correctly; for example, ROR by 31 equals ROL by 1.

Reset
REQ-025 rst high SHALL force, asynchronously: state=IDLE, result=0, out_valid=0, in_ready=0, remaining=0, and flags=0 when present.
REQ-026 rst asserted during BUSY or DONE SHALL discard the operation with no output handshake; the first request is accepted on the first edge after rst deasserts.

Configuration
REQ-027 With macro ROT_SHIFT_FLAGS_EN defined, flag_z SHALL be 1 iff result==0, and flag_c SHALL be the last bit shifted out.
REQ-028 For ROR, flag_c SHALL be the final result MSB; for ROL, the final result LSB.
REQ-029 For amt=0, flag_c SHALL be 0.
REQ-030 Without ROT_SHIFT_FLAGS_EN, flag_c and flag_z SHALL be absent and there SHALL be no flag logic; all other behaviour is identical.

Structure
REQ-031 A shared package/header SHALL hold the mode encodings (MODE_ROR, MODE_ROL, MODE_SRL, MODE_SRA) and the state encodings.
REQ-032 Sub-module rot_step SHALL be a combinational shift of the data by s (0..STEP) positions in the given mode, with an sra fill input and a carry-out output; it is instantiated once.

Verification
REQ-033 WIDTH=32, STEP=1, ROR: num=0x00000001, amt=1 -> result=0x80000000, out_valid in cycle N+2, flag_c=1.
REQ-034 STEP=4, SRA: num=0x80000000, amt=31 -> result=0xFFFFFFFF after 8 BUSY cycles; out_valid in cycle N+9.
REQ-035 ROL with amt=0: num=0x12345678 -> result=0x12345678 in cycle N+1, flag_c=0, flag_z=0.
REQ-036 SRL: num=0x0000000F, amt=4 -> result=0, flag_z=1, flag_c=1.
REQ-037 With out_ready held low for 5 cycles in DONE -> result is stable and in_ready stays 0; out_ready=1 -> IDLE on the next edge.
REQ-038 rst pulsed mid-BUSY (ROR amt=20, STEP=1) -> out_valid is never asserted for that request, and outputs are 0 immediately.

Source files
------------

// File: rtl/rot_shift_pkg.sv
// Purpose: shared mode and FSM state encodings for the rotate/shift unit.
// Latency: n/a (types only).
// Backpressure: n/a.
package rot_shift_pkg;

    typedef enum logic [1:0] {
        MODE_ROR = 2'b00,
        MODE_ROL = 2'b01,
        MODE_SRL = 2'b10,
        MODE_SRA = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/rot_shift_unit_step.sv
// Purpose: combinational rotate/shift of data_in by s (0..STEP) positions, one iteration of the unit.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
// Ports: data_in/data_out operand and shifted value, s step amount, mode operation,
//        sra_fill bit fed in at the MSB for SRA, carry_out last bit shifted out (0 when s==0).
module rot_step
    import rot_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int AW   = $clog2(WIDTH),
    localparam int SW   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic [SW-1:0]    s,
    input  mode_t            mode,
    input  logic             sra_fill,
    output logic [WIDTH-1:0] data_out,
    output logic             carry_out
);

    logic [WIDTH-1:0] ror_v;
    logic [WIDTH-1:0] rol_v;
    logic [WIDTH-1:0] shr_v;
    logic             carry_right;
    logic             carry_left;

    always_comb begin
        ror_v = '0;
        rol_v = '0;
        shr_v = '0;
        for (int i = 0; i < WIDTH; i++) begin
            // WIDTH is a power of two, so AW-bit index arithmetic wraps mod WIDTH.
            ror_v[i] = data_in[AW'(i) + AW'(s)];
            rol_v[i] = data_in[AW'(i) - AW'(s)];
            if (i + int'(s) < WIDTH) begin
                shr_v[i] = ror_v[i];
            end else begin
                shr_v[i] = (mode == MODE_SRA) ? sra_fill : 1'b0;
            end
        end
    end

    // Right-going ops lose bit s-1 last; ROL loses bit WIDTH-s last.
    always_comb begin
        carry_right = 1'b0;
        carry_left  = 1'b0;
        if (s != '0) begin
            carry_right = data_in[AW'(int'(s) - 1)];
            carry_left  = data_in[AW'(WIDTH - int'(s))];
        end
    end

    always_comb begin
        data_out  = shr_v;
        carry_out = carry_right;
        case (mode)
            MODE_ROR: data_out = ror_v;
            MODE_ROL: begin
                data_out  = rol_v;
                carry_out = carry_left;
            end
            default: data_out = shr_v;
        endcase
    end

endmodule

// File: rtl/rot_shift_unit.sv
// Purpose: iterative rotate/shift unit (ROR/ROL/SRL/SRA) moving at most STEP bits per cycle.
// Latency: result valid 1+ceil(amt/STEP) cycles after acceptance.
// Backpressure: single op in flight; in_ready low until the result is taken with out_ready.
// Ports: clk/rst (async active-high), in_valid/in_ready/num/amt/mode request,
//        out_valid/out_ready/result response; flag_c/flag_z only when ROT_SHIFT_FLAGS_EN is defined.
module rot_shift_unit
    import rot_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         num,
    input  logic [$clog2(WIDTH)-1:0] amt,
    input  logic [1:0]               mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         result
`ifdef ROT_SHIFT_FLAGS_EN
    ,
    output logic                     flag_c,
    output logic                     flag_z
`endif
);

    localparam int AW = $clog2(WIDTH);
    localparam int SW = $clog2(STEP + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AW-1:0]    rem_q, rem_d;
    mode_t            mode_q, mode_d;
    logic [SW-1:0]    step_s;
    logic [WIDTH-1:0] step_out;
    logic             accept;

`ifdef ROT_SHIFT_FLAGS_EN
    logic             step_carry;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
`else
    logic             step_carry_unused;
`endif

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign result    = data_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        if (int'(rem_q) >= STEP) begin
            step_s = SW'(STEP);
        end else begin
            step_s = SW'(rem_q);
        end
    end

    // SRA fill comes from the working value's MSB, which never changes under SRA.
    rot_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .data_in   (data_q),
        .s         (step_s),
        .mode      (mode_q),
        .sra_fill  (data_q[WIDTH-1]),
        .data_out  (step_out),
`ifdef ROT_SHIFT_FLAGS_EN
        .carry_out (step_carry)
`else
        .carry_out (step_carry_unused)
`endif
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
`ifdef ROT_SHIFT_FLAGS_EN
        carry_d = carry_q;
        zero_d  = zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = num;
                    mode_d  = mode_t'(mode);
                    rem_d   = amt;
                    state_d = (amt != '0) ? BUSY : DONE;
`ifdef ROT_SHIFT_FLAGS_EN
                    carry_d = 1'b0;
                    zero_d  = (num == '0);
`endif
                end
            end
            BUSY: begin
                data_d = step_out;
                rem_d  = rem_q - AW'(step_s);
`ifdef ROT_SHIFT_FLAGS_EN
                carry_d = step_carry;
                zero_d  = (step_out == '0);
`endif
                if (rem_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            mode_q  <= MODE_ROR;
`ifdef ROT_SHIFT_FLAGS_EN
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
`ifdef ROT_SHIFT_FLAGS_EN
            carry_q <= carry_d;
            zero_q  <= zero_d;
`endif
        end
    end

`ifdef ROT_SHIFT_FLAGS_EN
    assign flag_c = carry_q;
    assign flag_z = zero_q;
`endif

endmodule

// File: tb/tb_rot_shift_unit.sv
// Purpose: directed bench for rot_shift_unit at WIDTH=32 with STEP=1 and STEP=4 side by side.
// Latency: checks first out_valid cycle against 1+ceil(amt/STEP) per instance.
// Backpressure: exercises DONE hold with out_ready low and reset during BUSY.
module tb_rot_shift_unit;
    import rot_shift_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] num;
    logic [4:0]  amt;
    logic [1:0]  mode;

    logic        in_ready1, out_valid1, in_ready4, out_valid4;
    logic [31:0] result1, result4;
`ifdef ROT_SHIFT_FLAGS_EN
    logic        fc1, fz1, fc4, fz4;
`endif

    always #5 clk = ~clk;

    rot_shift_unit #(.WIDTH(32), .STEP(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .num(num), .amt(amt), .mode(mode), .out_valid(out_valid1),
        .out_ready(out_ready), .result(result1)
`ifdef ROT_SHIFT_FLAGS_EN
        , .flag_c(fc1), .flag_z(fz1)
`endif
    );

    rot_shift_unit #(.WIDTH(32), .STEP(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .num(num), .amt(amt), .mode(mode), .out_valid(out_valid4),
        .out_ready(out_ready), .result(result4)
`ifdef ROT_SHIFT_FLAGS_EN
        , .flag_c(fc4), .flag_z(fz4)
`endif
    );

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] num;
        logic [4:0]  amt;
        logic [31:0] exp;
        logic        exp_c;
    } vec_t;

    vec_t vecs[12];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input int a, input int st);
        return 1 + (a + st - 1) / st;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int   lat1 = 0;
        int   lat4 = 0;
        logic rdy_seen = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d.in_ready", idx), {30'b0, in_ready4, in_ready1}, 32'h3);
        num = v.num; amt = v.amt; mode = v.mode; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        num = 32'hDEADDEAD; amt = 5'd7; mode = 2'b01;
        for (int c = 1; c <= 60 && (lat1 == 0 || lat4 == 0); c++) begin
            @(negedge clk);
            if (out_valid1 && lat1 == 0) lat1 = c;
            if (out_valid4 && lat4 == 0) lat4 = c;
            if (in_ready1 || in_ready4) rdy_seen = 1'b1;
        end
        chk($sformatf("v%0d.lat_step1", idx), lat1, exp_lat(int'(v.amt), 1));
        chk($sformatf("v%0d.lat_step4", idx), lat4, exp_lat(int'(v.amt), 4));
        chk($sformatf("v%0d.result_step1", idx), result1, v.exp);
        chk($sformatf("v%0d.result_step4", idx), result4, v.exp);
        chk($sformatf("v%0d.busy_in_ready", idx), {31'b0, rdy_seen}, 32'h0);
`ifdef ROT_SHIFT_FLAGS_EN
        chk($sformatf("v%0d.flags_step1", idx), {30'b0, fc1, fz1}, {30'b0, v.exp_c, v.exp == 32'h0});
        chk($sformatf("v%0d.flags_step4", idx), {30'b0, fc4, fz4}, {30'b0, v.exp_c, v.exp == 32'h0});
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk($sformatf("v%0d.release", idx), {28'b0, out_valid1, out_valid4, in_ready1, in_ready4}, 32'h3);
    endtask

    initial begin
        //          mode      num           amt    expected      carry
        vecs[0]  = '{MODE_ROR, 32'h00000001, 5'd1,  32'h80000000, 1'b1};
        vecs[1]  = '{MODE_SRA, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0};
        vecs[2]  = '{MODE_ROL, 32'h12345678, 5'd0,  32'h12345678, 1'b0};
        vecs[3]  = '{MODE_SRL, 32'h0000000F, 5'd4,  32'h00000000, 1'b1};
        vecs[4]  = '{MODE_ROR, 32'h80000001, 5'd31, 32'h00000003, 1'b0};
        vecs[5]  = '{MODE_ROL, 32'hF0000000, 5'd4,  32'h0000000F, 1'b1};
        vecs[6]  = '{MODE_SRA, 32'h7FFFFFF0, 5'd5,  32'h03FFFFFF, 1'b1};
        vecs[7]  = '{MODE_SRL, 32'hDEADBEEF, 5'd16, 32'h0000DEAD, 1'b1};
        vecs[8]  = '{MODE_ROR, 32'h12345678, 5'd8,  32'h78123456, 1'b0};
        vecs[9]  = '{MODE_SRA, 32'h80000000, 5'd0,  32'h80000000, 1'b0};
        vecs[10] = '{MODE_ROL, 32'hA5A5A5A5, 5'd31, 32'hD2D2D2D2, 1'b0};
        vecs[11] = '{MODE_SRA, 32'h8000F000, 5'd13, 32'hFFFC0007, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        num = 32'h0; amt = 5'd0; mode = 2'b00;

        // Reset state
        @(negedge clk);
        chk("reset.handshake", {28'b0, out_valid1, out_valid4, in_ready1, in_ready4}, 32'h0);
        chk("reset.result_step1", result1, 32'h0);
        chk("reset.result_step4", result4, 32'h0);
`ifdef ROT_SHIFT_FLAGS_EN
        chk("reset.flags", {28'b0, fc1, fz1, fc4, fz4}, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_vec(i, vecs[i]);
        end

        // DONE held with out_ready low; a new request must be ignored meanwhile
        @(negedge clk);
        num = 32'hF0F0F0F0; amt = 5'd4; mode = MODE_SRL; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) @(negedge clk);
        in_valid = 1'b1; num = 32'h11111111; amt = 5'd0; mode = MODE_ROR;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("hold%0d.result_step1", c), result1, 32'h0F0F0F0F);
            chk($sformatf("hold%0d.result_step4", c), result4, 32'h0F0F0F0F);
            chk($sformatf("hold%0d.handshake", c),
                {28'b0, out_valid1, out_valid4, in_ready1, in_ready4}, 32'hC);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("hold.release", {28'b0, out_valid1, out_valid4, in_ready1, in_ready4}, 32'h3);

        // Reset in the middle of BUSY discards the operation
        @(negedge clk);
        num = 32'h12345678; amt = 5'd20; mode = MODE_ROR; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) @(negedge clk);
        chk("midbusy.out_valid", {30'b0, out_valid1, out_valid4}, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("midbusy.async_handshake", {28'b0, out_valid1, out_valid4, in_ready1, in_ready4}, 32'h0);
        chk("midbusy.async_result1", result1, 32'h0);
        chk("midbusy.async_result4", result4, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        num = 32'hCAFEF00D; amt = 5'd0; mode = MODE_ROL; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("postrst.first_accept", {30'b0, out_valid1, out_valid4}, 32'h3);
        chk("postrst.result1", result1, 32'hCAFEF00D);
        chk("postrst.result4", result4, 32'hCAFEF00D);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        begin
            logic ghost = 1'b0;
            for (int c = 0; c < 25; c++) begin
                @(negedge clk);
                if (out_valid1 || out_valid4) ghost = 1'b1;
            end
            chk("postrst.no_ghost_valid", {31'b0, ghost}, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
